// File: rtl/rv_pkg.sv
`default_nettype none
// =============================================================================
// Module   : rv_pkg
// Brief    : Shared RV32I widths, opcode constants and the fetch queue entry type.
// Revision : 1.0 - initial release
// =============================================================================
package rv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [6:0] opcode_of(input logic [ILEN-1:0] instr);
        return instr[6:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// =============================================================================
// Module   : fetch_stage_if
// Brief    : Memory handshake, redirect and decode-side signals of the fetch stage.
// Revision : 1.0 - initial release
// =============================================================================
interface fetch_stage_if;
    import rv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            id_valid;
    logic            id_ready;
    logic [ILEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [6:0]      id_opcode;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  branch_taken, branch_target,
        output id_valid, id_instr, id_pc, id_opcode,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output branch_taken, branch_target,
        input  id_valid, id_instr, id_pc, id_opcode,
        output id_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// =============================================================================
// Module   : fetch_queue
// Brief    : In-order DEPTH-entry FIFO of fetched {pc, instr} with synchronous flush.
// Revision : 1.0 - initial release
// =============================================================================
module fetch_queue
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign w_push = push & (r_count != c_full);
    assign w_pop  = pop & (r_count != '0);

    // Storage is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// =============================================================================
// Module   : fetch_stage
// Brief    : RV32I fetch stage: PC, credit-limited word fetch, in-order queue to
//            decode, branch redirect with stale-response discard.
//            Optional macro PERF_CNT_EN adds perf_fetched / perf_flushed counters.
// Revision : 1.0 - initial release
// =============================================================================
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_flushed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] c_depth = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_discard;

    logic [CW-1:0]   w_count;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic            w_req;
    logic            w_fire;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic [XLEN-1:0] w_target;

    assign w_target = bus.branch_target & ~32'h3;

    // Credit rule: queued plus outstanding never exceeds the queue size.
    assign w_req  = !reset && !bus.branch_taken &&
                    (({1'b0, w_count} + {1'b0, r_inflight}) < c_depth);
    assign w_fire = w_req & bus.imem_gnt;
    assign w_push = bus.imem_rvalid & !bus.branch_taken & (r_discard == '0);
    assign w_drop = bus.imem_rvalid & !w_push;
    assign w_pop  = !w_empty & bus.id_ready & !bus.branch_taken;

    assign w_push_entry.pc    = r_resp_pc;
    assign w_push_entry.instr = bus.imem_rdata;

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.branch_taken),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .empty      (w_empty),
        .count      (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_fire) - CW'(bus.imem_rvalid);
            if (bus.branch_taken) begin
                r_pc      <= w_target;
                r_resp_pc <= w_target;
                // Everything still outstanding after this cycle belongs to the old path.
                r_discard <= r_inflight - CW'(bus.imem_rvalid);
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (bus.imem_rvalid && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
            end
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc;
    assign bus.id_valid  = !w_empty;
    assign bus.id_instr  = w_empty ? '0 : w_head.instr;
    assign bus.id_pc     = w_empty ? '0 : w_head.pc;
    assign bus.id_opcode = opcode_of(bus.id_instr);

`ifdef PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 32'(w_pop);
            r_perf_flushed <= r_perf_flushed
                              + (bus.branch_taken ? 32'(w_count) : 32'd0)
                              + 32'(w_drop);
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// =============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage against a queue-based reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fetch_stage;
    import rv_pkg::*;

    localparam int          DEPTH     = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC1 = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus0();
    fetch_stage_if bus1();

`ifdef PERF_CNT_EN
    logic [31:0] perf_fetched0, perf_flushed0, perf_fetched1, perf_flushed1;
`endif

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus0)
`ifdef PERF_CNT_EN
        , .perf_fetched (perf_fetched0)
        , .perf_flushed (perf_flushed0)
`endif
    );

    fetch_stage #(.RESET_PC(RESET_PC1), .DEPTH(DEPTH)) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
`ifdef PERF_CNT_EN
        , .perf_fetched (perf_fetched1)
        , .perf_flushed (perf_flushed1)
`endif
    );

    // Reference model: outstanding requests (with stale marks) and delivered entries.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          gcyc;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    pend_t       pend[$];
    ent_t        mq[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_fetched = 0;
    logic [31:0] m_flushed = 0;
    int          cycle = 0;
    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 0;
    bit          f1_prev = 0;
    logic [31:0] a1_prev = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ {a[15:0], 16'h0013};
    endfunction

    function bit exp_req();
        return !rst && !bus0.branch_taken && ((mq.size() + pend.size()) < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [31:0] h;
        chk("imem_req", 32'(bus0.imem_req), 32'(exp_req()));
        chk("imem_addr", bus0.imem_addr, m_pc);
        chk("id_valid", 32'(bus0.id_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            h = mq[0].instr;
            chk("id_pc", bus0.id_pc, mq[0].pc);
            chk("id_instr", bus0.id_instr, h);
            chk("id_opcode", 32'(bus0.id_opcode), 32'(h[6:0]));
        end else begin
            chk("id_pc_idle", bus0.id_pc, 32'h0);
            chk("id_instr_idle", bus0.id_instr, 32'h0);
        end
`ifdef PERF_CNT_EN
        chk("perf_fetched", perf_fetched0, m_fetched);
        chk("perf_flushed", perf_flushed0, m_flushed);
`endif
    endtask

    always @(negedge clk) begin
        if (chk_en) compare_model();
    end

    // Apply one cycle of inputs just after the active edge, then settle past negedge.
    task automatic drive(input bit g, input bit rdy, input bit br,
                         input logic [31:0] tgt, input bit rven);
        bus0.imem_gnt      = g;
        bus0.id_ready      = rdy;
        bus0.branch_taken  = br;
        bus0.branch_target = tgt;
        if (!rst && rven && pend.size() > 0 && pend[0].gcyc < cycle) begin
            bus0.imem_rvalid = 1'b1;
            bus0.imem_rdata  = mem_word(pend[0].addr);
        end else begin
            bus0.imem_rvalid = 1'b0;
            bus0.imem_rdata  = $urandom;
        end
        bus1.imem_gnt      = 1'b1;
        bus1.id_ready      = 1'b1;
        bus1.branch_taken  = 1'b0;
        bus1.branch_target = 32'h0;
        bus1.imem_rvalid   = f1_prev && !rst;
        bus1.imem_rdata    = mem_word(a1_prev);
        @(negedge clk);
        #1;
        f1_prev = bus1.imem_req && bus1.imem_gnt;
        a1_prev = bus1.imem_addr;
    endtask

    task automatic tick();
        bit    fire;
        pend_t p;
        ent_t  e;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            pend.delete();
            m_pc      = RESET_PC;
            m_fetched = 0;
            m_flushed = 0;
        end else begin
            fire = exp_req() && bus0.imem_gnt;
            if (!bus0.branch_taken && mq.size() > 0 && bus0.id_ready) begin
                void'(mq.pop_front());
                m_fetched++;
            end
            if (bus0.imem_rvalid) begin
                p = pend.pop_front();
                if (bus0.branch_taken || p.stale) begin
                    m_flushed++;
                end else begin
                    e.pc    = p.addr;
                    e.instr = bus0.imem_rdata;
                    mq.push_back(e);
                end
            end
            if (bus0.branch_taken) begin
                m_flushed += 32'(mq.size());
                mq.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                m_pc = bus0.branch_target & ~32'h3;
            end
            if (fire) begin
                p.addr  = m_pc;
                p.stale = 1'b0;
                p.gcyc  = cycle;
                pend.push_back(p);
                m_pc += 32'd4;
            end
        end
        cycle++;
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 32'h0, 0);
            if (i > 0) begin
                chk("rst_req", 32'(bus0.imem_req), 32'h0);
                chk("rst_valid", 32'(bus0.id_valid), 32'h0);
                chk("rst_addr", bus0.imem_addr, RESET_PC);
                chk("rst_pc", bus0.id_pc, 32'h0);
                chk("rst_instr", bus0.id_instr, 32'h0);
                chk("rst_addr1", bus1.imem_addr, RESET_PC1);
            end
            tick();
            chk_en = 1'b1;
        end
        rst = 1'b0;
    endtask

    task automatic wait_first_pc(input string name, input logic [31:0] exp_pc);
        bit found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            drive(1, 1, 0, 32'h0, 1);
            if (bus0.id_valid) begin
                chk(name, bus0.id_pc, exp_pc);
                found = 1;
            end
            tick();
        end
        if (!found) chk({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        int grants;

        // Back-to-back fetch after reset release; wrapping instance runs alongside.
        do_reset(3);
        for (int c = 0; c < 6; c++) begin
            drive(1, 1, 0, 32'h0, 1);
            case (c)
                0: begin
                    chk("t1_addr0", bus0.imem_addr, 32'h0);
                    chk("t1_valid0", 32'(bus0.id_valid), 32'h0);
                    chk("t6_addr0", bus1.imem_addr, 32'hFFFF_FFF8);
                end
                1: begin
                    chk("t1_addr1", bus0.imem_addr, 32'h4);
                    chk("t1_valid1", 32'(bus0.id_valid), 32'h0);
                    chk("t6_addr1", bus1.imem_addr, 32'hFFFF_FFFC);
                end
                2: begin
                    chk("t1_valid2", 32'(bus0.id_valid), 32'h1);
                    chk("t1_pc", bus0.id_pc, 32'h0);
                    chk("t1_instr", bus0.id_instr, 32'h0050_0093);
                    chk("t1_opcode", 32'(bus0.id_opcode), 32'(OPC_OPIMM));
                    chk("t6_addr2", bus1.imem_addr, 32'h0);
                    chk("t6_pc0", bus1.id_pc, 32'hFFFF_FFF8);
                end
                3: chk("t6_pc1", bus1.id_pc, 32'hFFFF_FFFC);
                5: chk("t6_pc2", bus1.id_pc, 32'h0);
                default: ;
            endcase
            tick();
        end

        // Decode stalled: credits cap outstanding work at DEPTH.
        do_reset(2);
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1, 0, 0, 32'h0, 1);
            if (bus0.imem_req && bus0.imem_gnt) grants++;
            if (c >= 2) begin
                chk("t2_req_off", 32'(bus0.imem_req), 32'h0);
                chk("t2_instr_hold", bus0.id_instr, 32'h0050_0093);
            end
            tick();
        end
        chk("t2_grants", 32'(grants), 32'(DEPTH));
        drive(1, 1, 0, 32'h0, 1);
        chk("t2_pc_a", bus0.id_pc, 32'h0);
        tick();
        drive(1, 1, 0, 32'h0, 1);
        chk("t2_pc_b", bus0.id_pc, 32'h4);
        tick();

        // Redirect with two requests in flight.
        do_reset(2);
        drive(1, 1, 0, 32'h0, 0); tick();
        drive(1, 1, 0, 32'h0, 0); tick();
        drive(0, 1, 1, 32'h103, 0);
        chk("t3_req_br", 32'(bus0.imem_req), 32'h0);
        tick();
        drive(1, 1, 0, 32'h0, 0);
        chk("t3_addr", bus0.imem_addr, 32'h100);
        tick();
        wait_first_pc("t3_first_pc", 32'h100);
`ifdef PERF_CNT_EN
        chk("t3_flushed", perf_flushed0, 32'h2);
`endif

        // Redirect colliding with a response and a ready decode.
        do_reset(2);
        drive(1, 0, 0, 32'h0, 1); tick();
        drive(1, 0, 0, 32'h0, 1); tick();
        drive(1, 1, 1, 32'h200, 1);
        chk("t4_valid_pre", 32'(bus0.id_valid), 32'h1);
        chk("t4_pc_pre", bus0.id_pc, 32'h0);
        chk("t4_rvalid_seen", 32'(bus0.imem_rvalid), 32'h1);
        tick();
        drive(1, 1, 0, 32'h0, 1);
        chk("t4_flushed", 32'(bus0.id_valid), 32'h0);
        chk("t4_addr", bus0.imem_addr, 32'h200);
`ifdef PERF_CNT_EN
        chk("t4_no_pop", perf_fetched0, 32'h0);
`endif
        tick();
        wait_first_pc("t4_first_pc", 32'h200);

        // Memory withholds grant: request and address hold.
        do_reset(2);
        for (int c = 0; c < 5; c++) begin
            drive(0, 1, 0, 32'h0, 0);
            chk("t5_req", 32'(bus0.imem_req), 32'h1);
            chk("t5_addr", bus0.imem_addr, RESET_PC);
            tick();
        end

        // Randomized traffic with a mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(2);
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 2) != 0));
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
